// File: rtl/lcd_write_arbiter_if.sv
// Requester handshake and LCD pin bundle for lcd_write_arbiter.
// The master side is the requester/pin environment; the slave side is the arbiter.
interface lcd_write_arbiter_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       busy;
  logic       done;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (
    output req0_valid, req0_rs, req0_data,
    output req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready, busy, done,
    input  LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    input  req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready, busy, done,
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Two-requester arbiter and timing sequencer for a write-only HD44780-style LCD bus.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority (req0 over req1) instead of round-robin.
module lcd_write_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int E_HIGH_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int EXEC_CYC   = 400,
  parameter int CLEAR_CYC  = 16000
) (
  input logic               clk,
  input logic               rst,
  lcd_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(CLEAR_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, EXEC} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_rs, w_rs_next;
  logic [7:0]       r_data, w_data_next;
  logic             r_done, w_done_next;

  logic w_grant0, w_grant1, w_accept, w_is_clear;

`ifdef LCD_ARB_FIXED_PRIO_EN
  assign w_grant0 = bus.req0_valid;
  assign w_grant1 = bus.req1_valid & ~bus.req0_valid;
`else
  // r_last = requester granted most recently; the other one wins a tie.
  logic r_last;

  assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end
`endif

  assign bus.req0_ready = (r_state == IDLE) & ~rst & w_grant0;
  assign bus.req1_ready = (r_state == IDLE) & ~rst & w_grant1;
  assign w_accept       = bus.req0_ready | bus.req1_ready;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign w_is_clear = ~r_rs & (r_data[7:2] == 6'd0) & (r_data != 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rs    <= w_rs_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rs_next    = r_rs;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SETUP;
          w_cnt_next   = SETUP_LD;
          w_rs_next    = w_grant0 ? bus.req0_rs   : bus.req1_rs;
          w_data_next  = w_grant0 ? bus.req0_data : bus.req1_data;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = ENABLE;
          w_cnt_next   = E_LD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ENABLE: begin
        if (r_cnt == '0) begin
          w_state_next = HOLD;
          w_cnt_next   = HOLD_LD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = EXEC;
          w_cnt_next   = w_is_clear ? CLEAR_LD : EXEC_LD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.LCD_E    = (r_state == ENABLE);
  assign bus.LCD_RS   = r_rs;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_DATA = r_data;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with default HD44780 timing at 10 MHz.
module tb_lcd_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  lcd_write_arbiter_if bus();

  lcd_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer from requester 'who'; accept is cycle 0, done expected at 6+w.
  task automatic xfer(input int who, input logic rs, input logic [7:0] d,
                      input int w, input bit withdraw, input string tag);
    int done_cyc;
    int e_pulses;
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_rs = rs; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_rs = rs; bus.req1_data = d;
    end
    #1;
    chk({tag, "_ready_win"},  (who == 0) ? bus.req0_ready : bus.req1_ready, 1);
    chk({tag, "_ready_lose"}, (who == 0) ? bus.req1_ready : bus.req0_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk({tag, "_c1_data"}, bus.LCD_DATA, d);
    chk({tag, "_c1_rs"},   bus.LCD_RS, rs);
    chk({tag, "_c1_e"},    bus.LCD_E, 0);
    chk({tag, "_c1_busy"}, bus.busy, 1);
    tick();
    chk({tag, "_c2_e"}, bus.LCD_E, 1);
    tick();
    tick();
    chk({tag, "_c4_e"}, bus.LCD_E, 1);
    tick();
    chk({tag, "_c5_e"}, bus.LCD_E, 0);
    done_cyc = -1;
    e_pulses = 0;
    for (int c = 6; c <= w + 30; c++) begin
      tick();
      if (withdraw && c == 10) begin
        bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h7e;
        #1;
      end
      if (withdraw && (c == 10 || c == 11)) chk({tag, "_wd_ready"}, bus.req1_ready, 0);
      if (withdraw && c == 12) begin
        bus.req1_valid = 1'b0;
        #1;
      end
      if (bus.LCD_E) e_pulses++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    chk({tag, "_done_cycle"}, done_cyc, 6 + w);
    chk({tag, "_exec_e"},     e_pulses, 0);
    chk({tag, "_done_busy"},  bus.busy, 0);
    chk({tag, "_keep_data"},  bus.LCD_DATA, d);
    if (withdraw) chk({tag, "_wd_ready_done"}, bus.req1_ready, 0);
    tick();
    chk({tag, "_after_done"}, bus.done, 0);
    if (withdraw) chk({tag, "_wd_idle"}, bus.busy, 0);
  endtask

  initial begin
    int got_done;
    int wait_cyc;
    int granted;
    int exp_order[4];
`ifdef LCD_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    // Reset with both requesters asserting valid: nothing may be granted.
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'haa;
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'hbb;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_e",      bus.LCD_E, 0);
    chk("rst_rs",     bus.LCD_RS, 0);
    chk("rst_rw",     bus.LCD_RW, 0);
    chk("rst_data",   bus.LCD_DATA, 8'h00);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_done",   bus.done, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Reset in the middle of the enable pulse drops the transfer.
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h55;
    #1;
    chk("mid_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    chk("mid_e_high", bus.LCD_E, 1);
    #2;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    chk("mid_async_e",    bus.LCD_E, 0);
    chk("mid_async_rs",   bus.LCD_RS, 0);
    chk("mid_async_data", bus.LCD_DATA, 8'h00);
    chk("mid_async_busy", bus.busy, 0);
    chk("mid_async_rdy",  bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    got_done = 0;
    for (int c = 0; c < 450; c++) begin
      tick();
      if (bus.done) got_done++;
    end
    chk("mid_no_done", got_done, 0);

    xfer(0, 1'b1, 8'h41, 400,   1'b0, "single");
    xfer(1, 1'b0, 8'h01, 16000, 1'b0, "clear");
    xfer(0, 1'b0, 8'h38, 400,   1'b0, "func_set");
    xfer(0, 1'b1, 8'h42, 400,   1'b1, "withdraw");

    // Tie: both held valid; each later grant lands in the done cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h30;
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h31;
    #1;
    for (int n = 0; n < 4; n++) begin
      wait_cyc = 0;
      while (!(bus.req0_ready || bus.req1_ready) && wait_cyc < 1000) begin
        tick();
        wait_cyc++;
      end
      chk($sformatf("tie%0d_timeout", n), (wait_cyc < 1000) ? 1 : 0, 1);
      granted = bus.req1_ready ? 1 : 0;
      chk($sformatf("tie%0d_grant", n), granted, exp_order[n]);
      chk($sformatf("tie%0d_one_rdy", n), bus.req0_ready & bus.req1_ready, 0);
      if (n > 0) begin
        chk($sformatf("tie%0d_b2b_done", n), bus.done, 1);
        chk($sformatf("tie%0d_b2b_busy", n), bus.busy, 0);
      end
      tick();
      chk($sformatf("tie%0d_busy", n), bus.busy, 1);
      chk($sformatf("tie%0d_data", n), bus.LCD_DATA, (exp_order[n] == 0) ? 8'h30 : 8'h31);
      tick();
      chk($sformatf("tie%0d_e_rise", n), bus.LCD_E, 1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_cyc = 0;
    while (!bus.done && wait_cyc < 1000) begin
      tick();
      wait_cyc++;
    end
    chk("tie_final_done", bus.done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the write-only 8-bit character-LCD bus between two independent requesters and sequences every transfer with correct setup, enable-pulse, hold and instruction-execution timing. Each requester hands over one command or data byte with a valid/ready handshake. The arbiter grants one requester at a time, drives LCD_E/LCD_RS/LCD_RW/LCD_DATA, and reports completion. It sits between the text-LCD content generators and the LCD pins; at the system 10 MHz clk, the default parameters meet HD44780 timing.

## Interface
- SETUP_CYC, 1: cycles RS/DATA are stable with LCD_E low before the enable pulse (≥1).
- E_HIGH_CYC, 3: LCD_E high width in cycles (≥1).
- HOLD_CYC, 1: cycles RS/DATA are held after LCD_E falls (≥1).
- EXEC_CYC, 400: wait for a normal instruction or data write (40 µs).
- CLEAR_CYC, 16000: wait for clear/home instructions (1.6 ms); must be ≥ EXEC_CYC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req0_valid  in  1  requester 0 has a byte.
- req0_rs  in  1  0 = instruction, 1 = data.
- req0_data  in  8  byte to write.
- req0_ready  out  1  accept strobe for requester 0.
- req1_valid, req1_rs, req1_data, req1_ready: same as requester 0, for requester 1.
- busy  out  1  high from the cycle after accept until the cycle before done.
- done  out  1  one-cycle pulse when a transfer's execution wait ends.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  tied 0 (write only).
- LCD_DATA  out  8  bus data.

## Operation
- States: IDLE, SETUP, ENABLE, HOLD, EXEC. One down-counter is sized $clog2(CLEAR_CYC+1) bits.
- Handshake:
  - reqN_ready is combinational, and is high only when state is IDLE, rst is low, reqN_valid is high and requester N wins arbitration.
  - Accept occurs when valid & ready are high in the same cycle; at accept, rs/data are latched internally.
  - A requester must hold valid/rs/data stable until accepted.
  - Deasserting valid before accept withdraws the request with no side effects.
- Arbitration:
  - Round-robin on a last-grant pointer. If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last time wins. The pointer updates only on accept.
  - Reset pointer value: last = 1, so req0 wins the first tie.
- Transitions:
  - IDLE → SETUP on accept.
  - SETUP (SETUP_CYC cycles) → ENABLE (E_HIGH_CYC cycles) → HOLD (HOLD_CYC cycles) → EXEC.
  - EXEC lasts CLEAR_CYC cycles if the latched byte has rs = 0 and data[7:2] = 0 with data ≠ 0 (clear 0x01, home 0x02/0x03); otherwise it lasts EXEC_CYC cycles.
  - EXEC → IDLE after the count expires; done is registered high for the first IDLE cycle.
- Outputs per state:
  - LCD_RS/LCD_DATA show the latched values from SETUP through HOLD and keep those values through EXEC and IDLE until the next accept.
  - LCD_E is 1 only in ENABLE.
- A new accept may occur in the same cycle done is high.
- Mid-operation rst: all state is cleared immediately, the transaction is dropped, and no done is produced.

## Timing
- Reset values: LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 8'h00, busy = 0, done = 0, both ready = 0, state IDLE.
- Accept at cycle 0:
  - LCD_RS/LCD_DATA are valid from cycle 1.
  - LCD_E rises at cycle 1+SETUP_CYC and falls at 1+SETUP_CYC+E_HIGH_CYC.
  - EXEC starts at 1+SETUP_CYC+E_HIGH_CYC+HOLD_CYC.
  - done occurs at cycle 1+SETUP_CYC+E_HIGH_CYC+HOLD_CYC+W, where W = EXEC_CYC or CLEAR_CYC.
- Defaults: normal write has done at cycle 406; clear has done at cycle 16006.
- Throughput is one transfer per (SETUP+E_HIGH+HOLD+W+1) cycles; the bus is never idle between back-to-back grants beyond that.

## Configuration
- LCD_ARB_FIXED_PRIO_EN:
  - When defined, arbitration is fixed priority: req0 always beats req1. The last-grant pointer is not implemented.
  - When undefined, round-robin applies as described above.

## Test plan
- Reset mid-ENABLE: rst pulse while LCD_E = 1 → LCD_E, LCD_RS, LCD_DATA = 0 asynchronously, no done, next accept works normally.
- Single write: req0 with rs = 1, data = 8'h41 → req0_ready high for 1 cycle. LCD_DATA = 8'h41 and LCD_RS = 1 from cycle 1; LCD_E high in cycles 2–4; done at cycle 406.
- Clear command: req1 with rs = 0, data = 8'h01 → EXEC lasts 16000 cycles, done at 16006. Then rs = 0, data = 8'h38 → done at 406.
- Tie, round-robin: both requesters held valid for 4 transfers → grant order 0, 1, 0, 1. With LCD_ARB_FIXED_PRIO_EN → order 0, 0, 0, 0 while req0 stays valid.
- Back-to-back: req0 valid again in the cycle done is high → accepted in that same cycle, LCD_E rises 2 cycles later, busy drops for no more than 1 cycle.
- Withdrawal: req1 valid for 2 cycles during EXEC and then dropped → no req1_ready, no extra LCD_E pulse.
